// File: rtl/uart_pkg.sv
// Shared types for the UART command receiver.
// UART_CMD_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
`ifdef UART_CMD_RX_PARITY_EN
        , S_PARITY
`endif
    } rx_state_e;

    // Odd count of ones across data plus parity bit means even parity failed.
    function automatic logic even_par_bad(input logic [DATA_W-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Reset value is parameterised so idle-high lines come up idle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART command receiver with glitch rejection and break handling.
// Define UART_CMD_RX_PARITY_EN for an even-parity bit and parity_err.
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] cmd,
    output logic              cmd_valid,
    output logic              frame_err,
`ifdef UART_CMD_RX_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV) + 1;

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);

    logic rxs;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rxs)
    );

    rx_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        bit_q;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] cmd_q;
    logic              vld_q;
    logic              ferr_q;
    logic              prev_q;
`ifdef UART_CMD_RX_PARITY_EN
    logic              pbad_q;
    logic              perr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            cmd_q   <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            prev_q  <= 1'b1;
`ifdef UART_CMD_RX_PARITY_EN
            pbad_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            vld_q  <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            prev_q <= rxs;
            cnt_q  <= cnt_q + CW'(1);
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (prev_q && !rxs) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rxs ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_q == DIV_M1) begin
                        cnt_q <= '0;
                        sh_q  <= {rxs, sh_q[DATA_W-1:1]};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_CMD_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == DIV_M1) begin
                        cnt_q   <= '0;
                        pbad_q  <= even_par_bad(sh_q, rxs);
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == DIV_M1) begin
                        cnt_q <= '0;
                        if (rxs) begin
                            state_q <= S_IDLE;
`ifdef UART_CMD_RX_PARITY_EN
                            if (pbad_q) begin
                                perr_q <= 1'b1;
                            end else begin
                                cmd_q <= sh_q;
                                vld_q <= 1'b1;
                            end
`else
                            cmd_q <= sh_q;
                            vld_q <= 1'b1;
`endif
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    cnt_q <= '0;
                    if (rxs) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = vld_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_CMD_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomised bench for uart_cmd_rx with an event-queue reference model.
// Build with UART_CMD_RX_PARITY_EN to exercise the parity variant.
module tb_uart_cmd_rx;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115200;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int HALF   = DIV / 2;
`ifdef UART_CMD_RX_PARITY_EN
    localparam int NPAR   = 1;
`else
    localparam int NPAR   = 0;
`endif
    // Two synchronizer flops plus the edge-detect cycle, then mid-start,
    // eight data bits, optional parity and the stop sample.
    localparam int LAT    = 3 + HALF + (9 + NPAR) * DIV;
    localparam int TOL    = 3;

    localparam int EV_OK   = 0;
    localparam int EV_FERR = 1;
    localparam int EV_PERR = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_CMD_RX_PARITY_EN
    logic       parity_err;
`else
    logic       parity_err = 1'b0;
`endif

    uart_cmd_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .frame_err  (frame_err),
`ifdef UART_CMD_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         t;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] exp_cmd = 8'h00;
    int         checks  = 0;
    int         errors  = 0;
    bit         mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Every cycle: strobes must match the queued expectations in kind,
    // data and timing, and cmd must hold the last good byte.
    always @(negedge clk) begin
        if (mon_en) begin
            int  kind;
            ev_t e;
            kind = -1;
            if (cmd_valid && frame_err) begin
                check("valid_and_ferr", 1, 0);
            end
            if (cmd_valid) kind = EV_OK;
            else if (frame_err) kind = EV_FERR;
            else if (parity_err) kind = EV_PERR;
            if (kind >= 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", kind, 99);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", kind, e.kind);
                    check("strobe_time_ok",
                          32'((cyc >= e.t - TOL) && (cyc <= e.t + TOL)), 1);
                    if (e.kind == EV_OK) exp_cmd = e.data;
                end
            end
            check("cmd_hold", cmd, exp_cmd);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        wait_cyc(DIV);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic par_bad);
        ev_t e;
        e.data = b;
        e.t    = cyc + LAT;
        if (!stop) e.kind = EV_FERR;
        else if (par_bad && NPAR == 1) e.kind = EV_PERR;
        else e.kind = EV_OK;
        exp_q.push_back(e);
        drive_bit(1'b0);
        check("busy_mid_frame", busy, 1);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (NPAR == 1) drive_bit((^b) ^ par_bad);
        drive_bit(stop);
    endtask

    logic [7:0] rb;
    logic       rstop;
    logic       rpar;

    initial begin
        wait_cyc(5);
        check("rst_cmd", cmd, 8'h00);
        check("rst_valid", cmd_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        wait_cyc(10);

        send_frame(8'h31, 1'b1, 1'b0);
        check("idle_after_31", busy, 0);
        check("cmd_31", cmd, 8'h31);

        rx = 1'b0;
        wait_cyc(100);
        rx = 1'b1;
        wait_cyc(300);
        check("glitch_busy", busy, 0);
        check("glitch_cmd", cmd, 8'h31);

        send_frame(8'h32, 1'b0, 1'b0);
        wait_cyc(2000);
        check("break_busy", busy, 1);
        rx = 1'b1;
        wait_cyc(20);
        check("break_exit_busy", busy, 0);
        check("ferr_cmd_kept", cmd, 8'h31);
        send_frame(8'h34, 1'b1, 1'b0);
        check("cmd_34", cmd, 8'h34);
        wait_cyc(30);

        send_frame(8'h32, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        check("b2b_cmd", cmd, 8'h34);
        wait_cyc(30);

        rb = 8'h33;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rb[i]);
        rx = rb[4];
        wait_cyc(HALF);
        rst_n   = 1'b0;
        exp_cmd = 8'h00;
        #1;
        check("midrst_cmd", cmd, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_valid", cmd_valid, 0);
        wait_cyc(5);
        rx = 1'b1;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(20);
        check("postrst_busy", busy, 0);
        send_frame(8'h30, 1'b1, 1'b0);
        check("cmd_30", cmd, 8'h30);
        wait_cyc(30);

        if (NPAR == 1) begin
            send_frame(8'h31, 1'b1, 1'b1);
            check("perr_cmd_kept", cmd, 8'h30);
            wait_cyc(30);
            send_frame(8'h31, 1'b1, 1'b0);
            check("par_ok_cmd", cmd, 8'h31);
            wait_cyc(30);
        end

        for (int n = 0; n < 4; n++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rpar  = (NPAR == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            send_frame(rb, rstop, rpar);
            if (!rstop) begin
                wait_cyc($urandom_range(10, 300));
                rx = 1'b1;
                wait_cyc(10);
            end
            wait_cyc($urandom_range(1, 40));
        end

        wait_cyc(100);
        check("pending_events", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
